axilite_mmio_regs: RTL and testbench

AXI4-Lite responder that terminates the core's MMIO master port in the uncore clock domain. It exposes a small register file: ID, scratch, LED control, a 64-bit cycle counter with an atomic high-word snapshot, and an edge-captured interrupt controller. It handles one write and one read transaction at a time, with independent read and write paths, and drives a level interrupt back to the core.

---
 rtl/axilite_mmio_regs_pkg.sv | 38 +++
 rtl/axilite_mmio_regs_intr.sv | 56 +++++
 rtl/axilite_mmio_regs.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_axilite_mmio_regs.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_mmio_regs_pkg.sv
// Shared constants for the uncore MMIO register block:
// register word indices, AXI response codes and FSM states.
package axilite_mmio_regs_pkg;

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_LED     = 3'd2;
  localparam logic [2:0] REG_CYC_LO  = 3'd3;
  localparam logic [2:0] REG_CYC_HI  = 3'd4;
  localparam logic [2:0] REG_ISTAT   = 3'd5;
  localparam logic [2:0] REG_IEN     = 3'd6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  function automatic logic [31:0] strb_mask(
    input logic [3:0] strb
  );
    strb_mask = {{8{strb[3]}}, {8{strb[2]}},
                 {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] m;
    m = strb_mask(strb);
    merge_bytes = (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/axilite_mmio_regs_intr.sv
// Interrupt capture: rising-edge detect into a W1C status
// register, enable mask and a registered level irq.
module intr_capture
  import axilite_mmio_regs_pkg::*;
#(
  parameter int NUM_INTR = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INTR-1:0] intr_in,
  input  logic [NUM_INTR-1:0] w1c_mask,
  input  logic                en_we,
  input  logic [NUM_INTR-1:0] en_wdata,
  input  logic [NUM_INTR-1:0] en_wmask,
  output logic [NUM_INTR-1:0] status,
  output logic [NUM_INTR-1:0] enable,
  output logic                irq
);

  logic [NUM_INTR-1:0] intr_d_q;
  logic [NUM_INTR-1:0] status_q, status_d;
  logic [NUM_INTR-1:0] enable_q, enable_d;
  logic                irq_q, irq_d;
  logic [NUM_INTR-1:0] edge_hit;

  always_comb begin
    edge_hit = intr_in & ~intr_d_q;
    // set is applied last so a coincident edge beats the clear
    status_d = (status_q & ~w1c_mask) | edge_hit;
    enable_d = enable_q;
    if (en_we) begin
      enable_d = (enable_q & ~en_wmask)
               | (en_wdata & en_wmask);
    end
    irq_d = |(status_q & enable_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_d_q <= '0;
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      intr_d_q <= intr_in;
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= irq_d;
    end
  end

  assign status = status_q;
  assign enable = enable_q;
  assign irq    = irq_q;

endmodule

// File: rtl/axilite_mmio_regs.sv
// AXI4-Lite MMIO responder: ID, scratch, LED, 64-bit cycle
// counter with high-word snapshot and interrupt controller.
module axilite_mmio_regs
  import axilite_mmio_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] ID_VALUE   = 32'h4C56_4E41,
  parameter int          NUM_INTR   = 2
) (
  input  logic                  uncoreclk,
  input  logic                  uncore_rstn,
  input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
  input  logic                  s_axilite_awvalid,
  output logic                  s_axilite_awready,
  input  logic [31:0]           s_axilite_wdata,
  input  logic [3:0]            s_axilite_wstrb,
  input  logic                  s_axilite_wvalid,
  output logic                  s_axilite_wready,
  output logic [1:0]            s_axilite_bresp,
  output logic                  s_axilite_bvalid,
  input  logic                  s_axilite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
  input  logic                  s_axilite_arvalid,
  output logic                  s_axilite_arready,
  output logic [31:0]           s_axilite_rdata,
  output logic [1:0]            s_axilite_rresp,
  output logic                  s_axilite_rvalid,
  input  logic                  s_axilite_rready,
  input  logic [NUM_INTR-1:0]   intr_in,
  output logic [7:0]            led,
  output logic                  irq
);

  logic clk, rst_n;
  assign clk   = uncoreclk;
  assign rst_n = uncore_rstn;

  // write path state
  logic [0:0]            w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  // read path state
  logic [0:0]  r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  // register file
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  led_q, led_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;

  logic [NUM_INTR-1:0] istat, ien;
  logic [NUM_INTR-1:0] w1c_mask;
  logic                en_we;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_now, w_now, commit;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [31:0]           wr_be;
  logic [31:0]           wr_wmask;
  logic [2:0]            wr_idx;
  logic                  wr_hit;

  logic [2:0]  rd_idx;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [31:0] istat_w, ien_w;

  assign aw_hs = s_axilite_awvalid & awready_q;
  assign w_hs  = s_axilite_wvalid & wready_q;
  assign b_hs  = bvalid_q & s_axilite_bready;
  assign ar_hs = s_axilite_arvalid & arready_q;
  assign r_hs  = rvalid_q & s_axilite_rready;

  assign aw_now = aw_held_q | aw_hs;
  assign w_now  = w_held_q | w_hs;
  assign commit = (w_state_q == W_IDLE)
                & aw_now & w_now;

  // a same-edge handshake bypasses the capture flops
  always_comb begin
    wr_addr  = aw_hs ? s_axilite_awaddr : awaddr_q;
    wr_data  = w_hs ? s_axilite_wdata : wdata_q;
    wr_strb  = w_hs ? s_axilite_wstrb : wstrb_q;
    wr_be    = strb_mask(wr_strb);
    wr_wmask = wr_data & wr_be;
    wr_idx   = wr_addr[4:2];
    wr_hit   = ~|wr_addr[ADDR_WIDTH-1:5]
             & (wr_addr[4:2] != 3'd7);
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axilite_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axilite_wdata;
          wstrb_d  = s_axilite_wstrb;
        end
        awready_d = ~aw_now;
        wready_d  = ~w_now;
        if (commit) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end
      end
      default: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    led_d     = led_q;
    w1c_mask  = '0;
    en_we     = 1'b0;
    if (commit && wr_hit) begin
      unique case (1'b1)
        (wr_idx == REG_SCRATCH):
          scratch_d = merge_bytes(scratch_q, wr_data, wr_strb);
        (wr_idx == REG_LED):
          if (wr_strb[0]) led_d = wr_data[7:0];
        (wr_idx == REG_ISTAT):
          w1c_mask = wr_wmask[NUM_INTR-1:0];
        (wr_idx == REG_IEN):
          en_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    istat_w = '0;
    ien_w   = '0;
    istat_w[NUM_INTR-1:0] = istat;
    ien_w[NUM_INTR-1:0]   = ien;
    rd_idx  = s_axilite_araddr[4:2];
    rd_hit  = ~|s_axilite_araddr[ADDR_WIDTH-1:5]
            & (rd_idx != 3'd7);
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (rd_hit) begin
      rd_resp = RESP_OKAY;
      unique case (rd_idx)
        REG_ID:      rd_data = ID_VALUE;
        REG_SCRATCH: rd_data = scratch_q;
        REG_LED:     rd_data = {24'd0, led_q};
        REG_CYC_LO:  rd_data = cnt_q[31:0];
        REG_CYC_HI:  rd_data = snap_q;
        REG_ISTAT:   rd_data = istat_w;
        REG_IEN:     rd_data = ien_w;
        default:     rd_data = '0;
      endcase
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    snap_d    = snap_q;
    cnt_d     = cnt_q + 64'd1;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_data;
          rresp_d   = rd_resp;
          if (rd_hit && rd_idx == REG_CYC_LO)
            snap_d = cnt_q[63:32];
        end
      end
      default: begin
        if (r_hs) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      scratch_q <= '0;
      led_q     <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      scratch_q <= scratch_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
    end
  end

  intr_capture #(
    .NUM_INTR (NUM_INTR)
  ) u_intr (
    .clk      (clk),
    .rst_n    (rst_n),
    .intr_in  (intr_in),
    .w1c_mask (w1c_mask),
    .en_we    (en_we),
    .en_wdata (wr_data[NUM_INTR-1:0]),
    .en_wmask (wr_be[NUM_INTR-1:0]),
    .status   (istat),
    .enable   (ien),
    .irq      (irq)
  );

  logic unused_bits;
  assign unused_bits = ^{wr_addr[1:0],
                         s_axilite_araddr[1:0],
                         wr_wmask, wr_be};

  assign s_axilite_awready = awready_q;
  assign s_axilite_wready  = wready_q;
  assign s_axilite_bvalid  = bvalid_q;
  assign s_axilite_bresp   = bresp_q;
  assign s_axilite_arready = arready_q;
  assign s_axilite_rvalid  = rvalid_q;
  assign s_axilite_rdata   = rdata_q;
  assign s_axilite_rresp   = rresp_q;
  assign led               = led_q;

endmodule

// File: tb/tb_axilite_mmio_regs.sv
// Directed bench for axilite_mmio_regs: per-feature tasks
// with hand-computed expectations.
module tb_axilite_mmio_regs;

  localparam logic [31:0] IDV = 32'h4C56_4E41;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [1:0]  intr_in = '0;
  logic [7:0]  led;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axilite_mmio_regs #(
    .ADDR_WIDTH (12),
    .ID_VALUE   (IDV),
    .NUM_INTR   (2)
  ) dut (
    .uncoreclk         (clk),
    .uncore_rstn       (rst_n),
    .s_axilite_awaddr  (awaddr),
    .s_axilite_awvalid (awvalid),
    .s_axilite_awready (awready),
    .s_axilite_wdata   (wdata),
    .s_axilite_wstrb   (wstrb),
    .s_axilite_wvalid  (wvalid),
    .s_axilite_wready  (wready),
    .s_axilite_bresp   (bresp),
    .s_axilite_bvalid  (bvalid),
    .s_axilite_bready  (bready),
    .s_axilite_araddr  (araddr),
    .s_axilite_arvalid (arvalid),
    .s_axilite_arready (arready),
    .s_axilite_rdata   (rdata),
    .s_axilite_rresp   (rresp),
    .s_axilite_rvalid  (rvalid),
    .s_axilite_rready  (rready),
    .intr_in           (intr_in),
    .led               (led),
    .irq               (irq)
  );

  task automatic axi_read(
    input  logic [11:0] a,
    output logic [31:0] d,
    output logic [1:0]  r,
    output int          lat
  );
    int n;
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic axi_write(
    input  logic [11:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    input  int          aw_dly,
    input  int          w_dly,
    input  int          bhold,
    output logic [1:0]  br,
    output int          lat,
    output logic [7:0]  led_b,
    output int          hold_bad
  );
    bit awd, wd;
    int c;
    awd = 0;
    wd = 0;
    c = 0;
    awaddr = a;
    wdata = d;
    wstrb = s;
    while (!(awd && wd) && c < 40) begin
      @(negedge clk);
      awvalid = !awd && (c >= aw_dly);
      wvalid = !wd && (c >= w_dly);
      if (awvalid && awready) awd = 1;
      if (wvalid && wready) wd = 1;
      c++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    br = bresp;
    led_b = led;
    hold_bad = 0;
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      if (!bvalid || awready || wready) hold_bad++;
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid,
         irq, led, rdata, bresp, rresp} !== '0) begin
      failures++;
      $display("FAIL reset_outs got aw%b w%b ar%b bv%b rv%b irq%b led%h rd%h exp all 0",
               awready, wready, arready, bvalid, rvalid,
               irq, led, rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset got %b exp 111",
               {awready, wready, arready});
    end
  endtask

  task automatic test_id_read();
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    axi_read(12'h000, d, r, lat);
    checks++;
    if (d !== IDV) begin
      failures++;
      $display("FAIL id_data got %h exp %h", d, IDV);
    end
    checks++;
    if (r !== 2'b00) begin
      failures++;
      $display("FAIL id_resp got %b exp 00", r);
    end
    checks++;
    if (lat !== 0) begin
      failures++;
      $display("FAIL id_latency got %0d exp 0", lat);
    end
  endtask

  task automatic test_scratch_w_first();
    logic [31:0] d;
    logic [1:0] r, br;
    logic [7:0] lb;
    int lat, hb;
    axi_write(12'h004, 32'hA5A5_1234, 4'b0101,
              3, 0, 0, br, lat, lb, hb);
    checks++;
    if (lat !== 0 || br !== 2'b00) begin
      failures++;
      $display("FAIL scratch_bvalid got lat %0d resp %b exp 0 00",
               lat, br);
    end
    axi_read(12'h004, d, r, lat);
    checks++;
    if (d !== 32'h00A5_0034) begin
      failures++;
      $display("FAIL scratch_strb got %h exp 00a50034", d);
    end
    axi_write(12'h000, 32'hDEAD_BEEF, 4'hF,
              0, 0, 0, br, lat, lb, hb);
    checks++;
    if (br !== 2'b00) begin
      failures++;
      $display("FAIL ro_write_resp got %b exp 00", br);
    end
    axi_read(12'h000, d, r, lat);
    checks++;
    if (d !== IDV) begin
      failures++;
      $display("FAIL ro_write_ignored got %h exp %h", d, IDV);
    end
  endtask

  task automatic test_led();
    logic [31:0] d;
    logic [1:0] r, br;
    logic [7:0] lb;
    int lat, hb;
    axi_write(12'h008, 32'h0000_00FF, 4'hF,
              0, 0, 0, br, lat, lb, hb);
    checks++;
    if (lb !== 8'hFF || lat !== 0) begin
      failures++;
      $display("FAIL led_at_bvalid got %h lat %0d exp ff 0",
               lb, lat);
    end
    axi_write(12'h008, 32'h1234_5600, 4'b1110,
              0, 0, 0, br, lat, lb, hb);
    axi_read(12'h008, d, r, lat);
    checks++;
    if (d !== 32'h0000_00FF || led !== 8'hFF) begin
      failures++;
      $display("FAIL led_strb got %h led %h exp 000000ff ff",
               d, led);
    end
  endtask

  task automatic test_bready_hold();
    logic [1:0] br;
    logic [7:0] lb;
    int lat, hb;
    axi_write(12'h004, 32'h0000_0001, 4'hF,
              0, 0, 5, br, lat, lb, hb);
    checks++;
    if (hb !== 0 || br !== 2'b00) begin
      failures++;
      $display("FAIL bready_hold got %0d bad cycles resp %b exp 0 00",
               hb, br);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0] r, br;
    logic [7:0] lb;
    int lat, hb;
    axi_read(12'h040, d, r, lat);
    checks++;
    if (r !== 2'b10 || d !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_rd got %b %h exp 10 0", r, d);
    end
    axi_read(12'h01C, d, r, lat);
    checks++;
    if (r !== 2'b10 || d !== 32'd0) begin
      failures++;
      $display("FAIL unmapped_rd7 got %b %h exp 10 0", r, d);
    end
    axi_write(12'h040, 32'hFFFF_FFFF, 4'hF,
              0, 0, 0, br, lat, lb, hb);
    checks++;
    if (br !== 2'b10) begin
      failures++;
      $display("FAIL unmapped_wr got %b exp 10", br);
    end
  endtask

  task automatic test_counter();
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    @(negedge clk);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cnt_q;
    // one edge passes before the AR handshake edge
    axi_read(12'h00C, d, r, lat);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL cyc_lo got %h exp ffffffff", d);
    end
    axi_read(12'h010, d, r, lat);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL cyc_hi_snap got %h exp 0", d);
    end
    checks++;
    if (dut.cnt_q[63:32] !== 32'd1) begin
      failures++;
      $display("FAIL cyc_live_hi got %h exp 1",
               dut.cnt_q[63:32]);
    end
    axi_read(12'h00C, d, r, lat);
    axi_read(12'h010, d, r, lat);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL cyc_hi_wrap got %h exp 1", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [1:0] r, br;
    logic [7:0] lb;
    int lat, hb;
    axi_write(12'h018, 32'h0000_0001, 4'hF,
              0, 0, 0, br, lat, lb, hb);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_idle got %b exp 0", irq);
    end
    @(negedge clk);
    intr_in[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_1cyc got %b exp 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_2cyc got %b exp 1", irq);
    end
    intr_in[0] = 1'b0;
    axi_read(12'h014, d, r, lat);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL istat_set got %h exp 1", d);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    logic [1:0] r, br;
    logic [7:0] lb;
    int lat, hb;
    axi_write(12'h014, 32'h0000_0001, 4'hF,
              0, 0, 0, br, lat, lb, hb);
    axi_read(12'h014, d, r, lat);
    checks++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_clear got %h irq %b exp 0 0", d, irq);
    end
    @(negedge clk);
    intr_in[0] = 1'b1;
    @(negedge clk);
    intr_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    // W1C commit edge coincides with a fresh rising edge
    awaddr = 12'h014;
    wdata = 32'h0000_0001;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    intr_in[0] = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin
      failures++;
      $display("FAIL w1c_race_bvalid got %b exp 1", bvalid);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    intr_in[0] = 1'b0;
    axi_read(12'h014, d, r, lat);
    checks++;
    if (d !== 32'd1 || irq !== 1'b1) begin
      failures++;
      $display("FAIL w1c_race got %h irq %b exp 1 1", d, irq);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    @(negedge clk);
    araddr = 12'h000;
    arvalid = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid) begin
        n++;
        checks++;
        if (rdata !== IDV) begin
          failures++;
          $display("FAIL b2b_data got %h exp %h", rdata, IDV);
        end
      end
    end
    arvalid = 1'b0;
    rready = 1'b0;
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL b2b_reads got %0d exp 4", n);
    end
    n = 0;
    awaddr = 12'h004;
    wdata = 32'h0000_0055;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    bready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bvalid) n++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    bready = 1'b0;
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL b2b_writes got %0d exp 4", n);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    @(negedge clk);
    araddr = 12'h004;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_rvalid got %b exp 1", rvalid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid, arready, led, irq, rdata} !== '0) begin
      failures++;
      $display("FAIL mid_reset got rv%b ar%b led%h irq%b rd%h exp 0",
               rvalid, arready, led, irq, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(12'h004, d, r, lat);
    checks++;
    if (d !== 32'd0 || lat !== 0) begin
      failures++;
      $display("FAIL mid_scratch got %h lat %0d exp 0 0", d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_scratch_w_first();
    test_led();
    test_bready_hold();
    test_unmapped();
    test_counter();
    test_irq();
    test_w1c();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
